// File: rtl/sample_rate_gen.sv
// Playback sample-rate generator: clamped half-period divider producing div_clk and sample_tick.
// Optional window rate monitor is built only when RATE_MONITOR_EN is defined.
module sample_rate_gen #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 1136,
    parameter int unsigned MIN_DIV     = 2,
    parameter int unsigned MAX_DIV     = 4000,
    parameter int unsigned MON_WINDOW  = 50_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [WIDTH-1:0] speed_control,
    output logic             div_clk,
    output logic             sample_tick,
    output logic [WIDTH-1:0] div_active,
    output logic             div_clamped,
    output logic [15:0]      tick_count,
    output logic [15:0]      ticks_per_window
);

    typedef enum logic [1:0] {
        STOPPED,
        PHASE_LO,
        PHASE_HI
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic             div_clk_next;
    logic             sample_tick_next;
    logic [WIDTH-1:0] div_active_next;
    logic             div_clamped_next;
    logic [15:0]      tick_count_next;

    logic             below_min;
    logic             above_max;
    logic [WIDTH-1:0] clamp_value;
    logic             boundary;

    assign below_min   = speed_control < WIDTH'(MIN_DIV);
    assign above_max   = speed_control > WIDTH'(MAX_DIV);
    assign clamp_value = below_min ? WIDTH'(MIN_DIV)
                       : above_max ? WIDTH'(MAX_DIV)
                       : speed_control;
    assign boundary    = (cnt == div_active - WIDTH'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= STOPPED;
            cnt         <= '0;
            div_clk     <= 1'b0;
            sample_tick <= 1'b0;
            div_active  <= WIDTH'(DEFAULT_DIV);
            div_clamped <= 1'b0;
            tick_count  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            div_clk     <= div_clk_next;
            sample_tick <= sample_tick_next;
            div_active  <= div_active_next;
            div_clamped <= div_clamped_next;
            tick_count  <= tick_count_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        div_clk_next     = div_clk;
        sample_tick_next = 1'b0;
        div_active_next  = div_active;
        div_clamped_next = div_clamped;
        tick_count_next  = tick_count;

        if (!enable) begin
            state_next   = STOPPED;
            cnt_next     = '0;
            div_clk_next = 1'b0;
        end else if (restart || state == STOPPED) begin
            // Start and realign share one path: fresh low half with a new count.
            state_next       = PHASE_LO;
            cnt_next         = '0;
            div_clk_next     = 1'b0;
            div_active_next  = clamp_value;
            div_clamped_next = below_min | above_max;
        end else if (boundary) begin
            cnt_next         = '0;
            div_active_next  = clamp_value;
            div_clamped_next = below_min | above_max;
            if (state == PHASE_LO) begin
                state_next       = PHASE_HI;
                div_clk_next     = 1'b1;
                sample_tick_next = 1'b1;
                tick_count_next  = tick_count + 16'd1;
            end else begin
                state_next   = PHASE_LO;
                div_clk_next = 1'b0;
            end
        end else begin
            cnt_next = cnt + WIDTH'(1);
        end
    end

`ifdef RATE_MONITOR_EN
    localparam int unsigned WIN_W = (MON_WINDOW > 1) ? $clog2(MON_WINDOW) : 1;

    logic [WIN_W-1:0] win_cnt;
    logic [15:0]      win_ticks;

    // A tick seen on the window-end cycle still belongs to the closing window.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt          <= '0;
            win_ticks        <= '0;
            ticks_per_window <= '0;
        end else if (win_cnt == WIN_W'(MON_WINDOW - 1)) begin
            win_cnt          <= '0;
            win_ticks        <= '0;
            ticks_per_window <= (sample_tick && win_ticks != '1) ? win_ticks + 16'd1 : win_ticks;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (sample_tick && win_ticks != '1) begin
                win_ticks <= win_ticks + 16'd1;
            end
        end
    end
`else
    assign ticks_per_window = '0;
`endif

endmodule

// File: tb/tb_sample_rate_gen.sv
// Scoreboard bench for sample_rate_gen: stimulus queues expected ticks, a monitor checks them.
module tb_sample_rate_gen;

`ifdef RATE_MONITOR_EN
    localparam int unsigned TB_WINDOW = 100;
`else
    localparam int unsigned TB_WINDOW = 50_000_000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        restart;
    logic [15:0] speed_control;
    logic        div_clk;
    logic        sample_tick;
    logic [15:0] div_active;
    logic        div_clamped;
    logic [15:0] tick_count;
    logic [15:0] ticks_per_window;

    always #5 clock = ~clock;

    sample_rate_gen #(
        .WIDTH      (16),
        .DEFAULT_DIV(1136),
        .MIN_DIV    (2),
        .MAX_DIV    (4000),
        .MON_WINDOW (TB_WINDOW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .restart         (restart),
        .speed_control   (speed_control),
        .div_clk         (div_clk),
        .sample_tick     (sample_tick),
        .div_active      (div_active),
        .div_clamped     (div_clamped),
        .tick_count      (tick_count),
        .ticks_per_window(ticks_per_window)
    );

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } tick_t;

    tick_t       exp_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    bit          mon_on    = 1'b0;
    logic [15:0] exp_count = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_tick(input int c);
        exp_count = exp_count + 16'd1;
        exp_q.push_back('{c, exp_count});
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_div_clk"}, div_clk, 0);
        check({tag, "_sample_tick"}, sample_tick, 0);
        check({tag, "_div_active"}, div_active, 1136);
        check({tag, "_div_clamped"}, div_clamped, 0);
        check({tag, "_tick_count"}, tick_count, 0);
        check({tag, "_ticks_per_window"}, ticks_per_window, 0);
    endtask

    task automatic load_check(input logic [15:0] sc, input int exp_active, input int exp_clamped);
        speed_control = sc;
        enable        = 1'b1;
        @(negedge clock);
        check("load_div_active", div_active, exp_active);
        check("load_div_clamped", div_clamped, exp_clamped);
        check("load_div_clk", div_clk, 0);
        enable = 1'b0;
        @(negedge clock);
    endtask

    // Monitor: every sample_tick must match the head of the expected queue.
    always @(negedge clock) begin : monitor
        tick_t t;
        if (mon_on) begin
            if (sample_tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
                end else begin
                    t = exp_q.pop_front();
                    check("tick_cycle", cyc, t.cyc);
                    check("tick_count", tick_count, t.cnt);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                t = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_tick: got none expected tick at cycle %0d", t.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        reset         = 1'b1;
        enable        = 1'b0;
        restart       = 1'b0;
        speed_control = 16'd4;
        repeat (3) @(negedge clock);
        check_reset_state("reset");

        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clock);
        check("stopped_div_clk", div_clk, 0);

        // D=4 start; speed goes to 6 during the third high half.
        enable = 1'b1;
        e      = cyc + 1;
        push_tick(e + 4);
        push_tick(e + 12);
        push_tick(e + 20);
        push_tick(e + 30);
        push_tick(e + 42);
        for (int t = e; t <= e + 23; t++) begin
            wait_until(t);
            check("div_clk_d4", div_clk, ((t - e) / 4) % 2);
            if (t == e) check("div_active_d4", div_active, 4);
            if (t == e + 21) speed_control = 16'd6;
            if (t == e + 22) check("div_active_hold", div_active, 4);
        end
        wait_until(e + 25);
        check("div_active_new", div_active, 6);

        // Drop enable on the cycle whose edge would raise div_clk.
        wait_until(e + 53);
        enable = 1'b0;
        wait_until(e + 54);
        check("drop_sample_tick", sample_tick, 0);
        check("drop_div_clk", div_clk, 0);
        check("drop_tick_count", tick_count, 5);
        wait_until(e + 56);
        enable = 1'b1;
        push_tick(e + 63);

        // Restart sampled on the edge of an expected tick suppresses it.
        wait_until(e + 74);
        restart = 1'b1;
        wait_until(e + 75);
        restart = 1'b0;
        check("restart_sample_tick", sample_tick, 0);
        check("restart_div_clk", div_clk, 0);
        check("restart_tick_count", tick_count, 6);
        check("restart_div_active", div_active, 6);
        push_tick(e + 81);
        wait_until(e + 82);
        enable = 1'b0;
        wait_until(e + 84);

        load_check(16'd1, 2, 1);
        load_check(16'hFFF0, 4000, 1);
        load_check(16'd1136, 1136, 0);
        load_check(16'd2, 2, 0);
        load_check(16'd4000, 4000, 0);
        load_check(16'd4001, 4000, 1);
        load_check(16'd0, 2, 1);

        // Reset while running and enabled.
        speed_control = 16'd1;
        enable        = 1'b1;
        @(negedge clock);
        check("pre_reset_clamped", div_clamped, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("midreset");
        exp_count = '0;
        reset     = 1'b0;
        enable    = 1'b0;
        @(negedge clock);

`ifdef RATE_MONITOR_EN
        speed_control = 16'd5;
        enable        = 1'b1;
        e             = cyc + 1;
        for (int k = 0; k < 30; k++) push_tick(e + 5 + 10 * k);
        wait_until(e + 290);
        check("window_ticks", ticks_per_window, 10);
        wait_until(e + 298);
        enable = 1'b0;
        wait_until(e + 340);
        reset = 1'b1;
        @(negedge clock);
        check("window_after_reset", ticks_per_window, 0);
        exp_count = '0;
        reset     = 1'b0;
`else
        speed_control = 16'd2;
        enable        = 1'b1;
        e             = cyc + 1;
        for (int k = 0; k < 10; k++) push_tick(e + 2 + 4 * k);
        wait_until(e + 40);
        enable = 1'b0;
        check("tied_ticks_per_window", ticks_per_window, 0);
`endif

        repeat (4) @(negedge clock);
        check("pending_ticks", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
